// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// FSM state encoding and default operand width.
package mult_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mult_core.sv
// Unsigned shift-add datapath: one partial product per step.
// Loaded with operand magnitudes; the control FSM lives in the top.
module seq_mult_core #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc,
    output logic               last
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] addend;

    assign addend = {{WIDTH{1'b0}}, mcand} << cnt;
    assign last   = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (load) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (step) begin
            if (mplier[0]) begin
                acc <= acc + addend;
            end
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential signed/unsigned multiplier with start/busy/done handshake.
// Magnitudes go through the unsigned core; the sign is applied at the end.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] z
);

    state_t             state;
    logic               sign;
    logic [WIDTH-1:0]   mag_x;
    logic [WIDTH-1:0]   mag_y;
    logic [2*WIDTH-1:0] acc;
    logic               last;
    logic               load;
    logic               step;

    // The most negative value negates to itself, which reads correctly as unsigned
    assign mag_x = (is_signed && x[WIDTH-1]) ? -x : x;
    assign mag_y = (is_signed && y[WIDTH-1]) ? -y : y;
    assign load  = (state == IDLE) && start;
    assign step  = (state == CALC);

    seq_mult_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk (clk),
        .rst (rst),
        .load(load),
        .step(step),
        .a   (mag_x),
        .b   (mag_y),
        .acc (acc),
        .last(last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            z     <= '0;
            sign  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sign  <= is_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (last) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    z     <= sign ? -acc : acc;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench: WIDTH=8 and WIDTH=2 instances against a
// cycle-level behavioural model built on integer arithmetic.
module tb_seq_multiplier;

    logic clk = 1'b0;
    logic rst;
    logic armed = 1'b0;

    logic        s8, sg8, b8, d8;
    logic [7:0]  x8, y8;
    logic [15:0] z8;
    logic        s2, sg2, b2, d2;
    logic [1:0]  x2, y2;
    logic [3:0]  z2;

    int n_chk  = 0;
    int n_fail = 0;

    int          left8, left2;
    logic        mb8, md8, mb2, md2;
    logic [15:0] mz8, res8;
    logic [3:0]  mz2, res2;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8), .is_signed(sg8),
        .x(x8), .y(y8), .busy(b8), .done(d8), .z(z8)
    );

    seq_multiplier #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(s2), .is_signed(sg2),
        .x(x2), .y(y2), .busy(b2), .done(d2), .z(z2)
    );

    function automatic int ref_z(int a, int b, bit sg, int w);
        int sa, sb;
        sa = (sg && a[w-1]) ? a - (1 << w) : a;
        sb = (sg && b[w-1]) ? b - (1 << w) : b;
        return (sa * sb) & ((1 << (2 * w)) - 1);
    endfunction

    task automatic chk(input bit ok, input string nm,
                       input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s t=%0t got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Model: an accepted start yields done WIDTH+1 edges later
    always @(posedge clk) begin
        if (rst) begin
            left8 = 0; mb8 = 0; md8 = 0; mz8 = '0;
            left2 = 0; mb2 = 0; md2 = 0; mz2 = '0;
        end else begin
            md8 = 0;
            if (left8 > 0) begin
                left8--;
                if (left8 == 0) begin
                    md8 = 1; mb8 = 0; mz8 = res8;
                end
            end else if (s8) begin
                res8  = 16'(ref_z(int'(x8), int'(y8), sg8, 8));
                left8 = 9;
                mb8   = 1;
            end
            md2 = 0;
            if (left2 > 0) begin
                left2--;
                if (left2 == 0) begin
                    md2 = 1; mb2 = 0; mz2 = res2;
                end
            end else if (s2) begin
                res2  = 4'(ref_z(int'(x2), int'(y2), sg2, 2));
                left2 = 3;
                mb2   = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk(b8 === mb8, "busy8", {15'd0, b8}, {15'd0, mb8});
            chk(d8 === md8, "done8", {15'd0, d8}, {15'd0, md8});
            chk(z8 === mz8, "z8", z8, mz8);
            chk(b2 === mb2, "busy2", {15'd0, b2}, {15'd0, mb2});
            chk(d2 === md2, "done2", {15'd0, d2}, {15'd0, md2});
            chk(z2 === mz2, "z2", {12'd0, z2}, {12'd0, mz2});
        end
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sg);
        @(negedge clk);
        x8 = a; y8 = b; sg8 = sg; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0; x8 = 8'($urandom); y8 = 8'($urandom); sg8 = 1'($urandom);
    endtask

    task automatic wait8(input logic [15:0] exp, input string nm);
        for (int k = 0; k < 40 && d8 !== 1'b1; k++) @(negedge clk);
        chk(d8 === 1'b1 && z8 === exp, nm, z8, exp);
    endtask

    initial begin
        int k;
        rst = 1'b1;
        s8 = 0; sg8 = 0; x8 = '0; y8 = '0;
        s2 = 0; sg2 = 0; x2 = '0; y2 = '0;
        @(negedge clk);
        armed = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk(b8 === 1'b0 && d8 === 1'b0 && z8 === 16'h0, "reset8", z8, 16'h0);

        op8(8'd13, 8'd11, 1'b0);  wait8(16'd143,  "u13x11");
        op8(8'hFD, 8'd7,  1'b1);  wait8(16'hFFEB, "s-3x7");
        op8(8'h80, 8'h80, 1'b1);  wait8(16'h4000, "sminxmin");
        op8(8'h80, 8'h01, 1'b1);  wait8(16'hFF80, "sminx1");
        op8(8'hFF, 8'hFF, 1'b0);  wait8(16'hFE01, "uffxff");
        op8(8'hFF, 8'hFF, 1'b1);  wait8(16'h0001, "s-1x-1");
        op8(8'h00, 8'h9C, 1'b1);  wait8(16'h0000, "szero");

        // Ignored start mid-operation, then a start in the done cycle
        op8(8'd20, 8'd6, 1'b0);
        @(negedge clk);
        x8 = 8'd5; y8 = 8'd5; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0; x8 = 8'd99;
        wait8(16'd120, "ignore_start");
        x8 = 8'd7; y8 = 8'd9; sg8 = 1'b0; s8 = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            s8 = 1'b0;
            k++;
        end while (d8 !== 1'b1 && k < 30);
        chk(k == 10, "b2b_latency", 16'(k), 16'd10);
        chk(z8 === 16'd63, "b2b_z", z8, 16'd63);

        // Reset mid-operation aborts with no done
        op8(8'd33, 8'd3, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk(b8 === 1'b0 && d8 === 1'b0 && z8 === 16'h0, "abort", z8, 16'h0);
        k = 0;
        repeat (12) begin
            @(negedge clk);
            if (d8 === 1'b1) k++;
        end
        chk(k == 0, "no_done_after_abort", 16'(k), 16'd0);
        op8(8'd33, 8'd3, 1'b0);  wait8(16'd99, "after_abort");

        // Random traffic, including starts while busy and rare resets
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            s8  = ($urandom_range(0, 3) == 0);
            sg8 = 1'($urandom);
            x8  = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            y8  = ($urandom_range(0, 9) == 0) ? 8'h80 : 8'($urandom);
            rst = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        s8 = 1'b0; rst = 1'b0;
        repeat (12) @(negedge clk);

        // Exhaustive WIDTH=2 in both modes
        for (int sg = 0; sg < 2; sg++) begin
            for (int a = 0; a < 4; a++) begin
                for (int b = 0; b < 4; b++) begin
                    @(negedge clk);
                    x2 = 2'(a); y2 = 2'(b); sg2 = 1'(sg); s2 = 1'b1;
                    @(negedge clk);
                    s2 = 1'b0;
                    for (int t = 0; t < 10 && d2 !== 1'b1; t++) @(negedge clk);
                    chk(d2 === 1'b1 && z2 === 4'(ref_z(a, b, 1'(sg), 2)), "w2",
                        {12'd0, z2}, 16'(ref_z(a, b, 1'(sg), 2)));
                end
            end
        end
        @(negedge clk);
        chk(z2 === 4'h1, "w2_last_s-1x-1", {12'd0, z2}, 16'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Parametrised sequential shift-add multiplier, the successor to the combinational 2-bit multiplier. It computes z = x * y over WIDTH-bit operands in unsigned or two's-complement mode and produces a 2*WIDTH-bit product. A start/busy/done handshake allows it to share a datapath with slower control logic. It iterates one partial product per clock, trading latency for area.

Parameters:
WIDTH, 8, operand width in bits (>= 2); product is 2*WIDTH bits
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only in IDLE
is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
x  input  WIDTH  multiplicand; sampled with start
y  input  WIDTH  multiplier; sampled with start
busy  output  1  high while an operation is in progress (CALC, SIGN)
done  output  1  one-cycle pulse; z is valid from this cycle
z  output  2*WIDTH  product, registered, held until the next done

Behaviour:
- Reset: when rst is sampled high at a clock edge: state=IDLE, busy=0, done=0, z=0, counter=0, internal registers cleared. Takes priority over every other event, including mid-operation (the operation is aborted and no done is issued).
- States: IDLE -> CALC -> SIGN -> IDLE.
- IDLE: busy=0. If start=1 at edge N: latch |x| and |y| (magnitudes when is_signed=1, raw otherwise), latch the result sign = x[MSB]^y[MSB] & is_signed, clear the accumulator, counter=0, go to CALC.
- CALC: busy=1. Each edge: if the multiplier LSB is 1, accumulator += multiplicand << counter; multiplier >>= 1; counter++. After WIDTH edges (N+1..N+WIDTH), go to SIGN.
- SIGN: busy=1. At edge N+WIDTH+1: z <= sign ? -acc : acc (2*WIDTH-bit two's complement); done <= 1; go to IDLE.
- Latency: done is high in the cycle after edge N+WIDTH+1 (WIDTH+2 edges including the start edge). For WIDTH=8, the start edge is N and done is visible after edge N+9.
- done deasserts at the next edge. busy=0 in the done cycle, and a start in the done cycle is accepted (back-to-back throughput of one result per WIDTH+2 cycles).
- start while busy=1 is ignored. Changes to x, y and is_signed after the start edge do not affect the result.
- Width rules: magnitude of the most negative operand (-2^(WIDTH-1)) fits in WIDTH unsigned bits. The product of two most-negative values = +2^(2*WIDTH-2), which fits without overflow. The accumulator is 2*WIDTH bits and never overflows.
- Zero operands: the full latency is still taken (no early termination), and z=0 with no negative zero.
- z holds its last value between operations. It is not cleared by start.

Decomposition:
- Shared package mult_pkg: state enum type (IDLE, CALC, SIGN, 2-bit encoding) and the default WIDTH constant.
- One natural sub-module: seq_mult_core. It holds the unsigned shift-add datapath (accumulator, shifting multiplier, counter) and is controlled by load/step inputs from the FSM in seq_multiplier. Sign handling stays in the top.

Test Plan:
1. WIDTH=8, unsigned, x=8'd13, y=8'd11, start pulse at edge N -> busy=1 at edges N+1..N+9, done=1 only after edge N+9, z=16'd143.
2. WIDTH=8, signed: x=8'hFD (-3), y=8'd7 -> z=16'hFFEB (-21). Then x=8'h80, y=8'h80 -> z=16'h4000. Then x=8'h80, y=8'h01 -> z=16'hFF80.
3. WIDTH=8, unsigned, x=8'hFF, y=8'hFF -> z=16'hFE01. The same operands with is_signed=1 -> z=16'h0001.
4. Handshake: assert start again at edges N+3 with x=5 and y=5 (ignored) and change x mid-operation -> the first result is unaffected. A new start in the done cycle is accepted, giving the next done exactly WIDTH+2 cycles later.
5. Reset at edge N+4 mid-operation -> the next cycle shows busy=0, done=0, z=0, and no done pulse follows. A subsequent start completes normally.
6. WIDTH=2 exhaustive: all 16 (x,y) pairs in both modes -> z matches x*y (unsigned) and $signed(x)*$signed(y) (signed) for every pair.
